// File: rtl/encoder_scan.sv
// encoder_scan: sequential 8-to-3 priority encoder (inverse of the active-low
// 3-to-8 decoder). Captures an active-low request word and emits the index of
// each asserted line, one per accepted valid/ready handshake.
// Optional build macro ENC_LSB_FIRST_EN: serve lowest index first instead of
// the default highest-index-first (74148-style) priority.
module encoder_scan #(
  parameter int unsigned IW = 3
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic [1:0]         iEna,
  input  logic [2**IW-1:0]   iData,
  input  logic               iLoad,
  input  logic               iReady,
  output logic [IW-1:0]      oIndex,
  output logic               oValid,
  output logic               oBusy,
  output logic               oGs_n,
  output logic               oDone
);

  localparam int unsigned N = 2**IW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q,  mask_d;
  logic [IW-1:0] index_q, index_d;
  logic          valid_q, valid_d;
  logic          gs_n_q,  gs_n_d;

  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  clr_oh;
  logic [N-1:0]  mask_next;

  // Priority select over an active-high mask; later loop hits win.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] m);
    logic [IW-1:0] idx;
    idx = '0;
`ifdef ENC_LSB_FIRST_EN
    for (int unsigned i = N; i > 0; i--) begin
      if (m[i-1]) idx = IW'(i - 1);
    end
`else
    for (int unsigned i = 0; i < N; i++) begin
      if (m[i]) idx = IW'(i);
    end
`endif
    return idx;
  endfunction

  // Enable decode, request inversion and mask-after-accept computation.
  always_comb begin
    en             = iEna[1] & ~iEna[0];
    req            = ~iData;
    clr_oh         = '0;
    clr_oh[index_q] = 1'b1;
    mask_next      = mask_q & ~clr_oh;
  end

  // Next-state logic for the scan FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    index_d = index_q;
    valid_d = valid_q;
    gs_n_d  = gs_n_q;
    case (state_q)
      S_IDLE: begin
        if (iLoad && en) begin
          mask_d = req;
          if (req != '0) begin
            state_d = S_EMIT;
            index_d = pick(req);
            valid_d = 1'b1;
            gs_n_d  = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_EMIT: begin
        if (!en) begin
          // Abort wins over a coincident handshake; oIndex is left as-is.
          state_d = S_IDLE;
          mask_d  = '0;
          valid_d = 1'b0;
          gs_n_d  = 1'b1;
        end else if (valid_q && iReady) begin
          mask_d = mask_next;
          if (mask_next != '0) begin
            index_d = pick(mask_next);
          end else begin
            valid_d = 1'b0;
            gs_n_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
        valid_d = 1'b0;
        gs_n_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      gs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      index_q <= index_d;
      valid_q <= valid_d;
      gs_n_q  <= gs_n_d;
    end
  end

  assign oIndex = index_q;
  assign oValid = valid_q;
  assign oGs_n  = gs_n_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = (state_q == S_DONE);

endmodule
